pipe_ctrl_tracker: RTL and testbench
====================================

# pipe_ctrl_tracker

Pipelined control tracker for the ARM pipeline: carries each decoded instruction's destination register and control flags through Execute, Memory and Writeback. It produces the stage-tagged signals the hazard logic consumes and applies the hazard logic's flush and stall decisions to those signals. It is the producer side of the forwarding/stall interface. It also keeps saturating stall/flush event counters for performance debug.

## Interface

Parameters:
- CNT_W, 16, width of stall/flush event counters

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; synchronous, active-low
- RegWriteD, MemtoRegD, PCSrcD, BranchD  in  1 each  decode-stage control flags
- ra1D, ra2D, wa3D  in  4 each  decode-stage source and destination register numbers
- CondExE  in  1  condition-check pass for the instruction in Execute
- StallD  in  1  decode stall from hazard logic (counted only)
- FlushE  in  1  bubble insert into Execute
- ClrCnt  in  1  synchronous clear of both counters
- ra1E, ra2E, wa3E  out  4 each  Execute-stage register numbers
- MemtoRegE, PCSrcE  out  1 each  raw (ungated) Execute flags
- BranchTakenE  out  1  combinational: BranchE & CondExE
- wa3M, RegWriteM, PCSrcM  out  4/1/1  Memory stage
- wa3WB, RegWriteWB, PCSrcWB  out  4/1/1  Writeback stage
- StallCnt, FlushCnt  out  CNT_W each  event counters

## Operation

- Each pipeline stage register holds a record: valid, reg_write, mem_to_reg, pc_src, branch, ra1, ra2, wa3.
- D→E transfer:
  - If !rst_n or FlushE: E record is all zeros.
  - Otherwise E takes the D inputs, with valid=1.
  - E always advances; there is no Execute stall.
- E→M transfer, with condition gating applied:
  - RegWriteM = RegWriteE & CondExE
  - PCSrcM = PCSrcE & CondExE
  - mem_to_reg is gated the same way.
  - valid and wa3 are copied unchanged.
- M→WB transfer: plain copy.
- A failed-condition instruction continues as a valid bubble with no write and no PC update.
- Counters:
  - StallCnt increments on each cycle with StallD=1.
  - FlushCnt increments on each cycle with FlushE=1 & !StallD (branch flushes only; load-use bubbles are excluded).
  - Both counters saturate at all-ones.
  - ClrCnt has priority over increment.

## Timing

- Reset: every registered output is 0, including StallCnt and FlushCnt. BranchTakenE is 0 because BranchE is 0.
- Latency: a D input appears on the E outputs after 1 clk, on M after 2, and on WB after 3.
- BranchTakenE is valid in the same cycle as BranchE and CondExE, with no register.
- FlushE is sampled at the edge and affects E only. Instructions already in M and WB continue.
- FlushE and StallD both high in the same cycle: E gets a bubble, StallCnt increments, FlushCnt holds.
- rst_n low mid-stream: every stage clears at the same edge, so in-flight writes are lost by design. The counters clear too.
- Counter at all-ones with the increment condition true: the counter holds. ClrCnt in the same cycle clears it to 0.
- There are no X outputs after the first reset edge.

## Structure

- Shared package pipe_ctrl_pkg holds:
  - typedef ctrl_rec_t, a packed struct of the record fields above
  - constant CTRL_BUBBLE, the all-zero record
  - typedef reg_addr_t, logic [3:0]
- Sub-module pipe_ctrl_stage: a one-stage record register with inputs clk, rst_n, flush and d, and output q.
  - It is instantiated three times, for E, M and WB.
  - flush is tied to 0 for M and WB.
  - Condition gating sits between the E and M instances in the top level.
- The counters live in the top level as two instances of a local saturating-counter always block.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with random D inputs → all outputs 0 and counters 0.
- Propagation: drive RegWriteD=1, wa3D=4'h5, CondExE=1:
  - cycle+1: wa3E=5
  - cycle+2: wa3M=5, RegWriteM=1
  - cycle+3: wa3WB=5, RegWriteWB=1
- Condition fail: PCSrcD=1, wa3D=4'hF, CondExE=0 in Execute → PCSrcE=1, then PCSrcM=0 and RegWriteM=0; wa3M=F.
- Branch flush: BranchD=1 with CondExE=1 → BranchTakenE=1 in the Execute cycle. Then FlushE=1 for 1 cycle → next E record is zero and FlushCnt=1.
- Load-use: StallD=1 and FlushE=1 for 3 cycles → E holds bubbles, StallCnt=3, FlushCnt=0.
- Saturation: force 65536 stall cycles → StallCnt=16'hFFFF and holds. ClrCnt=1 → StallCnt=0 at the next edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined control tracker: the per-stage control record
// and the condition-gating helper applied between Execute and Memory.
package pipe_ctrl_pkg;

  typedef logic [3:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      reg_write;
    logic      mem_to_reg;
    logic      pc_src;
    logic      branch;
    reg_addr_t ra1;
    reg_addr_t ra2;
    reg_addr_t wa3;
  } ctrl_rec_t;

  localparam ctrl_rec_t CTRL_BUBBLE = '0;

  // A failed condition keeps the slot valid but strips its architectural effects.
  function automatic ctrl_rec_t cond_gate(input ctrl_rec_t rec, input logic pass);
    ctrl_rec_t gated;
    gated            = rec;
    gated.reg_write  = rec.reg_write & pass;
    gated.mem_to_reg = rec.mem_to_reg & pass;
    gated.pc_src     = rec.pc_src & pass;
    return gated;
  endfunction

endpackage

// File: rtl/pipe_ctrl_tracker_if.sv
// Decode-side inputs, hazard decisions and stage-tagged outputs of the tracker.
// Timing contract: inputs are sampled at each rising clk; registered outputs
// change only at that edge, BranchTakenE follows CondExE combinationally.
interface pipe_ctrl_tracker_if #(parameter int CNT_W = 16);
  import pipe_ctrl_pkg::*;

  logic            RegWriteD, MemtoRegD, PCSrcD, BranchD;
  reg_addr_t       ra1D, ra2D, wa3D;
  logic            CondExE, StallD, FlushE, ClrCnt;
  reg_addr_t       ra1E, ra2E, wa3E;
  logic            MemtoRegE, PCSrcE, BranchTakenE;
  reg_addr_t       wa3M;
  logic            RegWriteM, PCSrcM;
  reg_addr_t       wa3WB;
  logic            RegWriteWB, PCSrcWB;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output RegWriteD, MemtoRegD, PCSrcD, BranchD, ra1D, ra2D, wa3D,
    output CondExE, StallD, FlushE, ClrCnt,
    input  ra1E, ra2E, wa3E, MemtoRegE, PCSrcE, BranchTakenE,
    input  wa3M, RegWriteM, PCSrcM, wa3WB, RegWriteWB, PCSrcWB,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  RegWriteD, MemtoRegD, PCSrcD, BranchD, ra1D, ra2D, wa3D,
    input  CondExE, StallD, FlushE, ClrCnt,
    output ra1E, ra2E, wa3E, MemtoRegE, PCSrcE, BranchTakenE,
    output wa3M, RegWriteM, PCSrcM, wa3WB, RegWriteWB, PCSrcWB,
    output StallCnt, FlushCnt
  );

endinterface

// File: rtl/pipe_ctrl_stage.sv
// One pipeline stage register holding a control record; flush inserts a bubble.
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  ctrl_rec_t d,
  output ctrl_rec_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) q <= CTRL_BUBBLE;
    else                 q <= d;
  end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Carries decoded control through Execute, Memory and Writeback for the hazard
// unit, applies flush and condition gating, and counts stall/flush events.
module pipe_ctrl_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  pipe_ctrl_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_rec_t decRec, exRec, memIn, memRec, wbRec;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic unusedWbBits;

  assign decRec = '{valid: 1'b1, reg_write: bus.RegWriteD, mem_to_reg: bus.MemtoRegD,
                    pc_src: bus.PCSrcD, branch: bus.BranchD,
                    ra1: bus.ra1D, ra2: bus.ra2D, wa3: bus.wa3D};

  pipe_ctrl_stage exStage  (.clk(clk), .rst_n(rst_n), .flush(bus.FlushE), .d(decRec), .q(exRec));
  assign memIn = cond_gate(exRec, bus.CondExE);
  pipe_ctrl_stage memStage (.clk(clk), .rst_n(rst_n), .flush(1'b0), .d(memIn), .q(memRec));
  pipe_ctrl_stage wbStage  (.clk(clk), .rst_n(rst_n), .flush(1'b0), .d(memRec), .q(wbRec));

  assign bus.ra1E         = exRec.ra1;
  assign bus.ra2E         = exRec.ra2;
  assign bus.wa3E         = exRec.wa3;
  assign bus.MemtoRegE    = exRec.mem_to_reg;
  assign bus.PCSrcE       = exRec.pc_src;
  assign bus.BranchTakenE = exRec.branch & bus.CondExE;
  assign bus.wa3M         = memRec.wa3;
  assign bus.RegWriteM    = memRec.reg_write;
  assign bus.PCSrcM       = memRec.pc_src;
  assign bus.wa3WB        = wbRec.wa3;
  assign bus.RegWriteWB   = wbRec.reg_write;
  assign bus.PCSrcWB      = wbRec.pc_src;

  // Writeback fields the hazard unit never looks at.
  assign unusedWbBits = ^{wbRec.valid, wbRec.mem_to_reg, wbRec.branch, wbRec.ra1, wbRec.ra2};

  // Load-use bubbles raise StallD together with FlushE; only branch flushes count.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.ClrCnt)                   stallCnt <= '0;
    else if (bus.StallD && stallCnt != CNT_MAX) stallCnt <= stallCnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.ClrCnt)                                 flushCnt <= '0;
    else if (bus.FlushE && !bus.StallD && flushCnt != CNT_MAX) flushCnt <= flushCnt + CNT_W'(1);
  end

  assign bus.StallCnt = stallCnt;
  assign bus.FlushCnt = flushCnt;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Directed bench for pipe_ctrl_tracker with a cycle-level reference model
// and literal checkpoints along the way.
module tb_pipe_ctrl_tracker;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    bit rw, m2r, pcs, br;
    int ra1, ra2, wa3;
  } instr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_tracker_if #(.CNT_W(CNT_W)) bus ();
  pipe_ctrl_tracker #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] exp_q[$];

  instr_t inE, inM, inWB;
  int stallModel, flushModel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    if (!rst_n) begin
      inE = '{default: 0};
      inM = '{default: 0};
      inWB = '{default: 0};
      stallModel = 0;
      flushModel = 0;
    end else begin
      inWB = inM;
      inM = inE;
      if (!bus.CondExE) begin
        inM.rw = 0;
        inM.m2r = 0;
        inM.pcs = 0;
      end
      if (bus.FlushE) inE = '{default: 0};
      else inE = '{rw: bus.RegWriteD, m2r: bus.MemtoRegD, pcs: bus.PCSrcD, br: bus.BranchD,
                   ra1: int'(bus.ra1D), ra2: int'(bus.ra2D), wa3: int'(bus.wa3D)};
      if (bus.ClrCnt) begin
        stallModel = 0;
        flushModel = 0;
      end else begin
        if (bus.StallD && stallModel < CNT_MAX) stallModel++;
        if (bus.FlushE && !bus.StallD && flushModel < CNT_MAX) flushModel++;
      end
    end
    exp_q.push_back(CNT_W'(stallModel));
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [CNT_W-1:0] expStall;
    #1;
    chk("ra1E", 32'(bus.ra1E), 32'(inE.ra1));
    chk("ra2E", 32'(bus.ra2E), 32'(inE.ra2));
    chk("wa3E", 32'(bus.wa3E), 32'(inE.wa3));
    chk("MemtoRegE", 32'(bus.MemtoRegE), 32'(inE.m2r));
    chk("PCSrcE", 32'(bus.PCSrcE), 32'(inE.pcs));
    chk("BranchTakenE", 32'(bus.BranchTakenE), 32'(inE.br & bus.CondExE));
    chk("wa3M", 32'(bus.wa3M), 32'(inM.wa3));
    chk("RegWriteM", 32'(bus.RegWriteM), 32'(inM.rw));
    chk("PCSrcM", 32'(bus.PCSrcM), 32'(inM.pcs));
    chk("wa3WB", 32'(bus.wa3WB), 32'(inWB.wa3));
    chk("RegWriteWB", 32'(bus.RegWriteWB), 32'(inWB.rw));
    chk("PCSrcWB", 32'(bus.PCSrcWB), 32'(inWB.pcs));
    chk("FlushCnt", 32'(bus.FlushCnt), 32'(flushModel));
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      expStall = exp_q.pop_front();
      chk("StallCnt", 32'(bus.StallCnt), 32'(expStall));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst_n = 1'b1;
    bus.RegWriteD = 1'b0; bus.MemtoRegD = 1'b0; bus.PCSrcD = 1'b0; bus.BranchD = 1'b0;
    bus.ra1D = 4'h0; bus.ra2D = 4'h0; bus.wa3D = 4'h0;
    bus.CondExE = 1'b0; bus.StallD = 1'b0; bus.FlushE = 1'b0; bus.ClrCnt = 1'b0;
  endtask

  task automatic nx();
    @(negedge clk);
    idle();
  endtask

  task automatic rand_d();
    bus.RegWriteD = 1'($urandom_range(0, 1));
    bus.MemtoRegD = 1'($urandom_range(0, 1));
    bus.PCSrcD    = 1'($urandom_range(0, 1));
    bus.BranchD   = 1'($urandom_range(0, 1));
    bus.ra1D      = 4'($urandom_range(0, 15));
    bus.ra2D      = 4'($urandom_range(0, 15));
    bus.wa3D      = 4'($urandom_range(0, 15));
    bus.CondExE   = 1'($urandom_range(0, 1));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;

    // reset with random decode inputs
    repeat (2) begin
      nx(); rst_n = 1'b0; rand_d(); bus.StallD = 1'b1; bus.FlushE = 1'($urandom_range(0, 1));
    end
    #2;
    chk("rst_wa3E", 32'(bus.wa3E), 32'd0);
    chk("rst_RegWriteWB", 32'(bus.RegWriteWB), 32'd0);
    chk("rst_StallCnt", 32'(bus.StallCnt), 32'd0);
    chk("rst_FlushCnt", 32'(bus.FlushCnt), 32'd0);
    chk("rst_BranchTakenE", 32'(bus.BranchTakenE), 32'd0);

    // propagation E -> M -> WB
    nx(); bus.RegWriteD = 1'b1; bus.wa3D = 4'h5; bus.CondExE = 1'b1;
    nx(); bus.CondExE = 1'b1; #2;
    chk("prop_wa3E", 32'(bus.wa3E), 32'h5);
    nx(); bus.CondExE = 1'b1; #2;
    chk("prop_wa3M", 32'(bus.wa3M), 32'h5);
    chk("prop_RegWriteM", 32'(bus.RegWriteM), 32'd1);
    nx(); #2;
    chk("prop_wa3WB", 32'(bus.wa3WB), 32'h5);
    chk("prop_RegWriteWB", 32'(bus.RegWriteWB), 32'd1);

    // failed condition: valid bubble with no write, no PC update
    nx(); bus.PCSrcD = 1'b1; bus.RegWriteD = 1'b1; bus.MemtoRegD = 1'b1; bus.wa3D = 4'hF;
    nx(); bus.CondExE = 1'b0; #2;
    chk("cf_PCSrcE", 32'(bus.PCSrcE), 32'd1);
    chk("cf_MemtoRegE", 32'(bus.MemtoRegE), 32'd1);
    chk("cf_wa3E", 32'(bus.wa3E), 32'hF);
    nx(); #2;
    chk("cf_PCSrcM", 32'(bus.PCSrcM), 32'd0);
    chk("cf_RegWriteM", 32'(bus.RegWriteM), 32'd0);
    chk("cf_wa3M", 32'(bus.wa3M), 32'hF);

    // branch taken then flush
    nx(); bus.BranchD = 1'b1; bus.wa3D = 4'h3;
    nx(); bus.CondExE = 1'b1; #2;
    chk("br_BranchTakenE", 32'(bus.BranchTakenE), 32'd1);
    nx(); bus.FlushE = 1'b1; bus.RegWriteD = 1'b1; bus.wa3D = 4'h7; bus.ra1D = 4'h2; bus.CondExE = 1'b1;
    nx(); bus.CondExE = 1'b1; #2;
    chk("fl_wa3E", 32'(bus.wa3E), 32'd0);
    chk("fl_ra1E", 32'(bus.ra1E), 32'd0);
    chk("fl_BranchTakenE", 32'(bus.BranchTakenE), 32'd0);
    chk("fl_FlushCnt", 32'(bus.FlushCnt), 32'd1);

    // load-use: stall + flush together
    nx(); bus.ClrCnt = 1'b1;
    repeat (3) begin
      nx(); bus.StallD = 1'b1; bus.FlushE = 1'b1; bus.RegWriteD = 1'b1; bus.wa3D = 4'hA;
    end
    nx(); #2;
    chk("lu_StallCnt", 32'(bus.StallCnt), 32'd3);
    chk("lu_FlushCnt", 32'(bus.FlushCnt), 32'd0);
    chk("lu_wa3E", 32'(bus.wa3E), 32'd0);

    // reset mid-stream drops in-flight writes and counters
    nx(); bus.RegWriteD = 1'b1; bus.wa3D = 4'h9; bus.CondExE = 1'b1;
    nx(); bus.CondExE = 1'b1;
    nx(); rst_n = 1'b0; bus.CondExE = 1'b1; #2;
    chk("mr_pre_wa3M", 32'(bus.wa3M), 32'h9);
    nx(); #2;
    chk("mr_wa3M", 32'(bus.wa3M), 32'd0);
    chk("mr_RegWriteM", 32'(bus.RegWriteM), 32'd0);
    chk("mr_wa3WB", 32'(bus.wa3WB), 32'd0);
    chk("mr_StallCnt", 32'(bus.StallCnt), 32'd0);

    // mixed traffic checked by the model
    repeat (40) begin
      nx(); rand_d();
      bus.StallD = 1'($urandom_range(0, 3) == 0);
      bus.FlushE = 1'($urandom_range(0, 2) == 0);
      bus.ClrCnt = 1'($urandom_range(0, 15) == 0);
    end

    // stall counter saturation and clear priority
    nx(); bus.ClrCnt = 1'b1;
    for (int i = 0; i < CNT_MAX + 1; i++) begin
      nx(); bus.StallD = 1'b1;
    end
    nx(); bus.StallD = 1'b1; bus.ClrCnt = 1'b1; #2;
    chk("sat_StallCnt", 32'(bus.StallCnt), 32'hFFFF);
    nx(); #2;
    chk("clr_StallCnt", 32'(bus.StallCnt), 32'd0);

    nx(); nx();
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
